mem_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the PROCESSOR fetch stage (I-port) and load/store stage (D-port).
- Grants one transaction at a time and forwards it to the memory.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the pipeline and the memory model inside the processor top level.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and default widths for the memory arbiter.
package mips_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: D beats I unless the fairness force is raised
// while I is pending.
module mem_arb_pick
    import mips_pkg::*;
(
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  logic   i_force_i,
    output owner_e pick_o
);

    // Pick the next owner from the current requests.
    always_comb begin
        pick_o = OWN_NONE;
        if (d_req_i && !(i_force_i && i_req_i)) begin
            pick_o = OWN_D;
        end else if (i_req_i) begin
            pick_o = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between the fetch
// (I) and load/store (D) ports, one transaction at a time.
// Optional feature: define MEM_ARB_FAIR_EN to cap consecutive D grants at
// MAX_D_STREAK while I is waiting.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned AW           = DEF_AW,
    parameter int unsigned DW           = DEF_DW,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic [DW-1:0]   i_rdata,
    output logic            i_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_done
);

    localparam int unsigned BW = DW / 8;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_be_q, mem_be_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            i_ack_q, i_ack_d;
    logic            d_ack_q, d_ack_d;

    logic            i_force;
    owner_e          pick;

    mem_arb_pick u_pick (
        .i_req_i   (i_req),
        .d_req_i   (d_req),
        .i_force_i (i_force),
        .pick_o    (pick)
    );

`ifdef MEM_ARB_FAIR_EN
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;

    assign i_force = (streak_q >= SW'(MAX_D_STREAK));

    // Count D grants that starved a pending I; any other grant restarts the count.
    always_comb begin
        streak_d = streak_q;
        if (state_q == ST_IDLE) begin
            case (pick)
                OWN_I:   streak_d = '0;
                OWN_D:   begin
                    if (!i_req) begin
                        streak_d = '0;
                    end else if (streak_q < SW'(MAX_D_STREAK)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Streak counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign i_force = 1'b0;
`endif

    // Next-state and registered-output logic for IDLE -> BUSY -> RESP.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                case (pick)
                    OWN_D: begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                        owner_d     = OWN_D;
                        state_d     = ST_BUSY;
                    end
                    OWN_I: begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = i_addr;
                        mem_be_d   = '1;
                        owner_d    = OWN_I;
                        state_d    = ST_BUSY;
                    end
                    default: ;
                endcase
            end
            ST_BUSY: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_RESP;
                    // Stores leave the owner's read data untouched.
                    if (owner_q == OWN_I) begin
                        i_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            i_rdata_d = mem_rdata;
                        end
                    end else if (owner_q == OWN_D) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic [DW-1:0]   i_rdata;
    logic            i_ack;
    logic            d_req;
    logic            d_we;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_be;
    logic [DW-1:0]   d_rdata;
    logic            d_ack;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_rdata;
    logic            mem_done;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .MAX_D_STREAK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ack     (i_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the first BUSY cycle; holds mem_done low for lat cycles, then completes.
    task automatic serve(input string tag, input int lat, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
                         input logic [31:0] e_wdata);
        for (int k = 0; k <= lat; k++) begin
            check_eq({tag, ".mem_req"}, 64'(mem_req), 64'd1);
            check_eq({tag, ".mem_addr"}, 64'(mem_addr), 64'(e_addr));
            check_eq({tag, ".mem_we"}, 64'(mem_we), 64'(e_we));
            check_eq({tag, ".mem_be"}, 64'(mem_be), 64'(e_be));
            if (e_we) check_eq({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
            check_eq({tag, ".early_ack"}, 64'({i_ack, d_ack}), 64'd0);
            if (k == lat) begin
                mem_done  = 1'b1;
                mem_rdata = rdata;
            end
            step();
        end
        mem_done = 1'b0;
    endtask

    // Called in the RESP cycle.
    task automatic check_resp(input string tag, input logic e_iack, input logic e_dack);
        check_eq({tag, ".i_ack"}, 64'(i_ack), 64'(e_iack));
        check_eq({tag, ".d_ack"}, 64'(d_ack), 64'(e_dack));
        check_eq({tag, ".mem_req_low"}, 64'(mem_req), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_rdata = '0; mem_done = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst.mem_req", 64'(mem_req), 64'd0);
        check_eq("rst.mem_we", 64'(mem_we), 64'd0);
        check_eq("rst.mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst.mem_be", 64'(mem_be), 64'd0);
        check_eq("rst.mem_wdata", 64'(mem_wdata), 64'd0);
        check_eq("rst.acks", 64'({i_ack, d_ack}), 64'd0);
        check_eq("rst.i_rdata", 64'(i_rdata), 64'd0);
        check_eq("rst.d_rdata", 64'(d_rdata), 64'd0);

        // mem_done while IDLE is ignored
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check_eq("idle_done.mem_req", 64'(mem_req), 64'd0);
        step();
        check_eq("idle_done.acks", 64'({i_ack, d_ack}), 64'd0);

        // Single fetch, mem_done two cycles after mem_req
        i_req = 1'b1; i_addr = 32'h0000_0040;
        step();
        serve("fetch", 2, 32'h8C08_0004, 32'h40, 1'b0, 4'hF, 32'h0);
        check_resp("fetch", 1'b1, 1'b0);
        check_eq("fetch.i_rdata", 64'(i_rdata), 64'h8C08_0004);
        i_req = 1'b0;
        step();
        check_eq("fetch.ack_one_cycle", 64'({i_ack, d_ack}), 64'd0);

        // Simultaneous requests: store wins, then fetch
        i_req = 1'b1; i_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
        step();
        serve("simul_d", 0, 32'h1234_5678, 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
        check_resp("simul_d", 1'b0, 1'b1);
        check_eq("simul_d.d_rdata_kept", 64'(d_rdata), 64'd0);
        d_req = 1'b0;
        step();
        check_eq("simul.idle_gap", 64'({mem_req, i_ack, d_ack}), 64'd0);
        step();
        serve("simul_i", 1, 32'hCAFE_F00D, 32'h80, 1'b0, 4'hF, 32'h0);
        check_resp("simul_i", 1'b1, 1'b0);
        check_eq("simul_i.i_rdata", 64'(i_rdata), 64'hCAFE_F00D);
        i_req = 1'b0;
        step();

        // Long-latency load
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'b0011;
        step();
        serve("load7", 7, 32'h0BAD_F00D, 32'h200, 1'b0, 4'b0011, 32'h0);
        check_resp("load7", 1'b0, 1'b1);
        check_eq("load7.d_rdata", 64'(d_rdata), 64'h0BAD_F00D);
        check_eq("load7.i_rdata_kept", 64'(i_rdata), 64'hCAFE_F00D);
        d_req = 1'b0;
        // mem_done during RESP is ignored
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        step();
        check_eq("resp_done.acks", 64'({i_ack, d_ack}), 64'd0);

        // Byte-enable store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h0000_AB00; d_be = 4'b0010;
        step();
        serve("bstore", 2, 32'hFFFF_FFFF, 32'h204, 1'b1, 4'b0010, 32'h0000_AB00);
        check_resp("bstore", 1'b0, 1'b1);
        check_eq("bstore.d_rdata_kept", 64'(d_rdata), 64'h0BAD_F00D);
        d_req = 1'b0;
        step();

        // Reset mid-BUSY, then a late mem_done
        i_req = 1'b1; i_addr = 32'h300;
        step();
        check_eq("rstbusy.mem_req", 64'(mem_req), 64'd1);
        rst = 1'b1; i_req = 1'b0;
        step();
        rst = 1'b0;
        check_eq("rstbusy.mem_req_low", 64'(mem_req), 64'd0);
        check_eq("rstbusy.acks", 64'({i_ack, d_ack}), 64'd0);
        mem_done = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_done = 1'b0;
        check_eq("late_done.acks", 64'({i_ack, d_ack}), 64'd0);
        check_eq("late_done.mem_req", 64'(mem_req), 64'd0);
        i_req = 1'b1; i_addr = 32'h304;
        step();
        serve("after_rst", 0, 32'h0102_0304, 32'h304, 1'b0, 4'hF, 32'h0);
        check_resp("after_rst", 1'b1, 1'b0);
        check_eq("after_rst.i_rdata", 64'(i_rdata), 64'h0102_0304);
        i_req = 1'b0;
        step();

        // Both requests held continuously
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
        for (int g = 0; g < 6; g++) begin
            logic exp_i;
`ifdef MEM_ARB_FAIR_EN
            exp_i = (g == 4);
`else
            exp_i = 1'b0;
`endif
            step();
            serve($sformatf("stream%0d", g), 0, 32'h1000 + 32'(g),
                  exp_i ? 32'h500 : 32'h400, 1'b0, 4'hF, 32'h0);
            check_resp($sformatf("stream%0d", g), exp_i, !exp_i);
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        step();
        check_eq("end.idle", 64'({mem_req, i_ack, d_ack}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
